// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel APB PWM block: channel FSM state
// type, register word offsets inside the global and per-channel windows, the
// layout of the per-channel register slots and the CFG bit positions.
// No ports; imported by apb_pwm_multi and pwm_channel.
// -----------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chState_e;

  // Channel register windows start at CH_BASE and repeat every CH_STRIDE bytes
  localparam int CH_BASE   = 'h10;
  localparam int CH_STRIDE = 'h10;

  // Word offsets (address bits [3:2]) inside the global window
  localparam logic [1:0] REG_ENABLE = 2'd0;
  localparam logic [1:0] REG_DONE   = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;

  // Word offsets (address bits [3:2]) inside a channel window
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY   = 2'd1;
  localparam logic [1:0] REG_PULSES = 2'd2;
  localparam logic [1:0] REG_CFG    = 2'd3;

  localparam int CFG_INVERT_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM channel: IDLE/RUN FSM, period counter, pulse counter, shadowed
// period/duty and the registered output.
// Ports:
//   clk_i, resetn_i   clock, synchronous active-low reset
//   start_i           ENABLE written with this channel's bit = 1
//   stop_i            ENABLE written with this channel's bit = 0
//   period_i, duty_i  live PERIOD/DUTY registers (sampled into shadows)
//   pulses_i          pulse count, 0 = continuous
//   invert_i          output polarity
//   pwm_o             registered PWM output
//   done_pulse_o      one-cycle strobe when a finite run completes
// -----------------------------------------------------------------------------
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [CNT_W-1:0] pulses_i,
  input  logic             invert_i,
  output logic             pwm_o,
  output logic             done_pulse_o
);

  chState_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulseCnt_q, pulseCnt_d;
  logic [CNT_W-1:0] perSh_q, perSh_d;
  logic [CNT_W-1:0] dutySh_q, dutySh_d;
  logic             pwm_q, pwm_d;
  logic             wrap;
  logic             lastWrap;
  logic             restart;

  // End of a period, and whether that period is the last one of a finite run.
  // The compare is one bit wider so pulseCnt_q + 1 can never wrap around.
  assign wrap     = (state_q == CH_RUN) && (cnt_q == perSh_q);
  assign lastWrap = wrap && (pulses_i != '0) &&
                    (({1'b0, pulseCnt_q} + (CNT_W+1)'(1)) >= {1'b0, pulses_i});
  // A 1 written to ENABLE starts from idle, and also wins over an auto-finish
  assign restart  = start_i && ((state_q == CH_IDLE) || lastWrap);

  // State register
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= CH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a bus stop or a finished pulse train returns to idle,
  // a bus restart keeps the channel running
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: begin
        if (start_i) state_d = CH_RUN;
      end
      CH_RUN: begin
        if (stop_i)        state_d = CH_IDLE;
        else if (restart)  state_d = CH_RUN;
        else if (lastWrap) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // Datapath next values: counters clear on start/stop, shadows reload at
  // start and at every wrap so mid-period writes only hit the next period
  always_comb begin
    cnt_d      = cnt_q;
    pulseCnt_d = pulseCnt_q;
    perSh_d    = perSh_q;
    dutySh_d   = dutySh_q;
    if (stop_i) begin
      cnt_d = '0;
    end else if (restart) begin
      cnt_d      = '0;
      pulseCnt_d = '0;
      perSh_d    = period_i;
      dutySh_d   = duty_i;
    end else if (state_q == CH_RUN) begin
      if (wrap) begin
        cnt_d    = '0;
        perSh_d  = period_i;
        dutySh_d = duty_i;
        if (pulses_i != '0) pulseCnt_d = pulseCnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs: PWM level from the current count, and the completion strobe,
  // which a simultaneous ENABLE write suppresses
  always_comb begin
    pwm_d        = ((state_q == CH_RUN) && (cnt_q < dutySh_q)) ^ invert_i;
    done_pulse_o = lastWrap && !start_i && !stop_i;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q      <= '0;
      pulseCnt_q <= '0;
      perSh_q    <= '0;
      dutySh_q   <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pulseCnt_q <= pulseCnt_d;
      perSh_q    <= perSh_d;
      dutySh_q   <= dutySh_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/apb_pwm_multi.sv
// -----------------------------------------------------------------------------
// apb_pwm_multi
// Multi-channel APB PWM generator: APB register decode, ENABLE / DONE (w1c) /
// IRQ_EN registers, per-channel PERIOD/DUTY/PULSES/CFG, and NUM_CH channels.
// Ports:
//   clk_i, resetn_i        clock, synchronous active-low reset
//   psel_i, penable_i,
//   pwrite_i, paddr_i,
//   pwdata_i               APB request (zero wait states)
//   prdata_o, pready_o,
//   pslverr_o              APB response, combinational in the access phase
//   pwm_o                  registered PWM outputs, one per channel
//   irq_o                  level interrupt, |(DONE & IRQ_EN)
// -----------------------------------------------------------------------------
module apb_pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PADDR_W = 8
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [PADDR_W-1:0] paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  output logic [NUM_CH-1:0]  pwm_o,
  output logic               irq_o
);

  localparam int SLOT_LSB   = $clog2(CH_STRIDE);
  localparam int SLOT_W     = PADDR_W - SLOT_LSB;
  localparam int FIRST_SLOT = CH_BASE / CH_STRIDE;

  logic [NUM_CH-1:0] enable_q, done_q, irqEn_q, invert_q;
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  logic [CNT_W-1:0]  pulses_q [NUM_CH];

  logic [SLOT_W-1:0] slot;
  logic [1:0]        regSel;
  logic              globalSel;
  logic [NUM_CH-1:0] chSel;
  logic              xfer, wrXfer, wrGlobal, wrEnable;
  logic              hit;
  logic [31:0]       rdVal;
  logic [NUM_CH-1:0] startCh, stopCh, donePulse;
  logic              unusedBits;

  assign slot      = paddr_i[PADDR_W-1:SLOT_LSB];
  assign regSel    = paddr_i[3:2];
  assign globalSel = (slot == '0) && (regSel != 2'd3);
  assign xfer      = psel_i && penable_i;
  assign wrXfer    = xfer && pwrite_i;
  assign wrGlobal  = wrXfer && globalSel;
  assign wrEnable  = wrGlobal && (regSel == REG_ENABLE);
  assign unusedBits = ^{paddr_i[1:0], pwdata_i};

  // Channel window select: slot FIRST_SLOT+ch maps to channel ch; slots
  // beyond the last channel select nothing and so become error responses
  always_comb begin
    chSel = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chSel[ch] = (slot == SLOT_W'(FIRST_SLOT + ch));
    end
  end

  // Read mux and address hit; a miss drives the error response
  always_comb begin
    hit   = 1'b0;
    rdVal = '0;
    if (globalSel) begin
      hit = 1'b1;
      case (regSel)
        REG_ENABLE: rdVal = 32'(enable_q);
        REG_DONE:   rdVal = 32'(done_q);
        default:    rdVal = 32'(irqEn_q);
      endcase
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (chSel[ch]) begin
        hit = 1'b1;
        case (regSel)
          REG_PERIOD: rdVal = 32'(period_q[ch]);
          REG_DUTY:   rdVal = 32'(duty_q[ch]);
          REG_PULSES: rdVal = 32'(pulses_q[ch]);
          default:    rdVal = 32'(invert_q[ch]);
        endcase
      end
    end
  end

  assign prdata_o  = (xfer && !pwrite_i && hit) ? rdVal : 32'd0;
  assign pslverr_o = xfer && !hit;
  assign pready_o  = 1'b1;

  // Every ENABLE write tells each channel to start (bit 1) or stop (bit 0)
  assign startCh = {NUM_CH{wrEnable}} & pwdata_i[NUM_CH-1:0];
  assign stopCh  = {NUM_CH{wrEnable}} & ~pwdata_i[NUM_CH-1:0];

  // Register file. A bus write to ENABLE overrides the auto-clear at the end
  // of a run; a newly completing run overrides a DONE clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      enable_q <= '0;
      done_q   <= '0;
      irqEn_q  <= '0;
      invert_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        period_q[ch] <= '0;
        duty_q[ch]   <= '0;
        pulses_q[ch] <= '0;
      end
    end else begin
      if (wrGlobal && (regSel == REG_IRQ_EN)) irqEn_q <= pwdata_i[NUM_CH-1:0];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wrEnable)           enable_q[ch] <= pwdata_i[ch];
        else if (donePulse[ch]) enable_q[ch] <= 1'b0;
        if (donePulse[ch])
          done_q[ch] <= 1'b1;
        else if (wrGlobal && (regSel == REG_DONE) && pwdata_i[ch])
          done_q[ch] <= 1'b0;
        if (wrXfer && chSel[ch]) begin
          case (regSel)
            REG_PERIOD: period_q[ch] <= pwdata_i[CNT_W-1:0];
            REG_DUTY:   duty_q[ch]   <= pwdata_i[CNT_W-1:0];
            REG_PULSES: pulses_q[ch] <= pwdata_i[CNT_W-1:0];
            default:    invert_q[ch] <= pwdata_i[CFG_INVERT_BIT];
          endcase
        end
      end
    end
  end

  assign irq_o = |(done_q & irqEn_q);

  // One channel engine per output
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    pwm_channel #(
      .CNT_W(CNT_W)
    ) uChannel (
      .clk_i        (clk_i),
      .resetn_i     (resetn_i),
      .start_i      (startCh[g]),
      .stop_i       (stopCh[g]),
      .period_i     (period_q[g]),
      .duty_i       (duty_q[g]),
      .pulses_i     (pulses_q[g]),
      .invert_i     (invert_q[g]),
      .pwm_o        (pwm_o[g]),
      .done_pulse_o (donePulse[g])
    );
  end

endmodule

// File: tb/tb_apb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_apb_pwm_multi
// Directed self-checking bench for apb_pwm_multi (NUM_CH=4, CNT_W=16,
// PADDR_W=8). Expected waveforms are hand-derived bit patterns.
// -----------------------------------------------------------------------------
module tb_apb_pwm_multi;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [7:0]  paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [3:0]  pwm_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        err;
  logic [31:0] obs, expv, irqObs, irqExp;

  apb_pwm_multi #(
    .NUM_CH (4),
    .CNT_W  (16),
    .PADDR_W(8)
  ) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .pwrite_i (pwrite_i),
    .paddr_i  (paddr_i),
    .pwdata_i (pwdata_i),
    .prdata_o (prdata_o),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o),
    .pwm_o    (pwm_o),
    .irq_o    (irq_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts, and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // APB write; the write commits at the posedge before the task returns
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(posedge clk_i);
    #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  // APB read; data and error are sampled mid access phase
  task automatic apbRead(input logic [7:0] addr, output logic [31:0] data,
                         output logic slvErr);
    @(negedge clk_i);
    psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = addr; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1;
    data   = prdata_o;
    slvErr = pslverr_o;
    @(posedge clk_i);
    #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    // Reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_pwm", 64'(pwm_o), 64'h0);
    checkOutput("rst_irq", 64'(irq_o), 64'h0);
    checkOutput("rst_pready", 64'(pready_o), 64'h1);
    checkOutput("rst_prdata", 64'(prdata_o), 64'h0);
    checkOutput("rst_pslverr", 64'(pslverr_o), 64'h0);
    resetn_i = 1'b1;

    for (int a = 0; a < 12; a += 4) begin
      apbRead(8'(a), rd, err);
      checkOutput($sformatf("rst_rd_%02h", a), 64'({err, rd}), 64'h0);
    end
    for (int ch = 0; ch < 4; ch++) begin
      for (int o = 0; o < 16; o += 4) begin
        apbRead(8'(16 + 16 * ch + o), rd, err);
        checkOutput($sformatf("rst_rd_%02h", 16 + 16 * ch + o), 64'({err, rd}), 64'h0);
      end
    end

    // ch0 continuous: 3 high / 7 low
    applyStimulus(8'h10, 32'd9);
    applyStimulus(8'h14, 32'd3);
    applyStimulus(8'h18, 32'd0);
    applyStimulus(8'h00, 32'h1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      obs[k]  = pwm_o[0];
      expv[k] = (k >= 1) && (((k - 1) % 10) < 3);
    end
    checkOutput("ch0_cont_wave", 64'(obs[29:0]), 64'(expv[29:0]));
    apbRead(8'h04, rd, err);
    checkOutput("ch0_done_zero", 64'(rd), 64'h0);
    apbRead(8'h00, rd, err);
    checkOutput("ch0_enable_rd", 64'(rd), 64'h1);

    // ch0 mid-period DUTY 3->8, from a fresh start
    applyStimulus(8'h00, 32'h0);
    applyStimulus(8'h00, 32'h1);
    fork
      applyStimulus(8'h14, 32'd8);
      for (int k = 0; k < 30; k++) begin
        @(negedge clk_i);
        obs[k] = pwm_o[0];
      end
    join
    // First period 3 high, then 8 high / 2 low
    expv = 32'b0011_1111_1100_1111_1111_0000_0001_110;
    checkOutput("ch0_duty_shadow", 64'(obs[29:0]), 64'(expv[29:0]));

    // ch1 finite run of 3 pulses with interrupt (stops ch0)
    applyStimulus(8'h20, 32'd4);
    applyStimulus(8'h24, 32'd2);
    applyStimulus(8'h28, 32'd3);
    applyStimulus(8'h08, 32'h2);
    applyStimulus(8'h00, 32'h2);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      obs[k]    = pwm_o[1];
      irqObs[k] = irq_o;
    end
    expv   = 32'b0000_0000_0000_0000_0001_1000_1100_0110;
    irqExp = 32'b0000_0001_1111_1111_1000_0000_0000_0000;
    checkOutput("ch1_pulse_wave", 64'(obs[24:0]), 64'(expv[24:0]));
    checkOutput("ch1_irq_wave", 64'(irqObs[24:0]), 64'(irqExp[24:0]));
    checkOutput("ch0_stopped", 64'(pwm_o[0]), 64'h0);
    apbRead(8'h00, rd, err);
    checkOutput("ch1_enable_clr", 64'(rd), 64'h0);
    apbRead(8'h04, rd, err);
    checkOutput("ch1_done_set", 64'(rd), 64'h2);
    applyStimulus(8'h04, 32'h2);
    @(negedge clk_i);
    checkOutput("ch1_irq_clr", 64'(irq_o), 64'h0);
    apbRead(8'h04, rd, err);
    checkOutput("ch1_done_clr", 64'(rd), 64'h0);

    // Boundaries on ch2: DUTY=0 constant low, DUTY>PERIOD constant high
    applyStimulus(8'h30, 32'd9);
    applyStimulus(8'h34, 32'd0);
    applyStimulus(8'h00, 32'h4);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      obs[k] = pwm_o[2];
    end
    checkOutput("ch2_duty0", 64'(obs[24:0]), 64'h0);
    applyStimulus(8'h00, 32'h0);
    applyStimulus(8'h34, 32'd10);
    applyStimulus(8'h00, 32'h4);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      obs[k]  = pwm_o[2];
      expv[k] = (k >= 1);
    end
    checkOutput("ch2_duty_over", 64'(obs[24:0]), 64'(expv[24:0]));
    applyStimulus(8'h00, 32'h0);

    // INVERT on idle ch3
    applyStimulus(8'h4C, 32'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("ch3_invert_idle", 64'(pwm_o), 64'h8);
    apbRead(8'h4C, rd, err);
    checkOutput("ch3_cfg_rd", 64'({err, rd}), 64'h1);

    // Error responses
    apbRead(8'h0C, rd, err);
    checkOutput("err_0c", 64'({err, rd}), 64'h1_0000_0000);
    apbRead(8'h50, rd, err);
    checkOutput("err_ch4", 64'({err, rd}), 64'h1_0000_0000);
    applyStimulus(8'h50, 32'h1234);
    apbRead(8'h10, rd, err);
    checkOutput("err_wr_ignored", 64'({err, rd}), 64'd9);

    // Reset mid-run (ch0 DUTY is 8, ch3 inverted)
    applyStimulus(8'h00, 32'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("prerst_pwm", 64'(pwm_o), 64'h9);
    resetn_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midrst_pwm", 64'(pwm_o), 64'h0);
    checkOutput("midrst_irq", 64'(irq_o), 64'h0);
    resetn_i = 1'b1;
    apbRead(8'h00, rd, err);
    checkOutput("postrst_enable", 64'(rd), 64'h0);
    apbRead(8'h14, rd, err);
    checkOutput("postrst_duty0", 64'(rd), 64'h0);
    apbRead(8'h4C, rd, err);
    checkOutput("postrst_cfg3", 64'(rd), 64'h0);
    repeat (12) @(negedge clk_i);
    checkOutput("postrst_pwm", 64'(pwm_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
